// File: rtl/fir_pkg.sv
// Shared FIR definitions: default sample width and the signed sample type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

    // Default sample width, shared with the FIR top level
    localparam int DEFAULT_DATA_WIDTH = 24;

    // Signed two's-complement sample as produced by the FIR
    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a word pushed at edge k is visible on rd_dat after edge k (no same-cycle bypass).
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
//
// Ports: core_clk/arst_n clock and async active-low reset; push/wr_dat write side;
//        pop/rd_dat read side (rd_dat = head word); full, empty, count status.
module fir_sync_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          push,
    input  logic [DW-1:0] wr_dat,
    input  logic          pop,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; only the bookkeeping below is reset.
    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers are AW bits and wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);

endmodule

// File: rtl/fir_decim_fifo.sv
// FIR output stage: keep 1 of DECIM_FACTOR strobed samples, buffer in a FWFT FIFO, sticky overflow.
// Latency: a kept sample appears on o_dout/o_valid one cycle after the strobe edge.
// Backpressure: valid/ready to the sink; kept samples arriving while full are dropped and flagged.
//
// Ports: i_clk, i_rst (async, active-low); i_en/i_din sample strobe and data;
//        i_ready sink ready; i_clr_ovf clears the overflow flag;
//        o_dout/o_valid head sample; o_count occupancy; o_overflow sticky drop flag.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DECIM_FACTOR = 4,
    parameter int FIFO_DEPTH   = 16,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_ready,
    input  logic                  i_clr_ovf,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic [AW:0]           o_count,
    output logic                  o_overflow
);

    // Phase counter needs at least one bit even when no decimation is applied.
    localparam int            PW         = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM_FACTOR - 1);

    logic [PW-1:0]         phase;
    logic                  keep;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dat;

    // Phase advances on every strobe, whether or not the kept sample fits.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            phase <= '0;
        end else if (i_en) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    assign keep = i_en && (phase == '0);
    assign pop  = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = keep && (!fifo_full || pop);
    assign drop = keep && fifo_full && !pop;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

    fir_sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst),
        .push     (push),
        .wr_dat   (i_din),
        .pop      (pop),
        .rd_dat   (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (o_count)
    );

    // Memory is unreset, so the head word is masked to zero while empty.
    assign o_valid = !fifo_empty;
    assign o_dout  = o_valid ? fifo_dat : '0;

endmodule
